knight_move_gen: RTL and testbench



---
 rtl/knight_move_gen_if.sv | 23 ++
 rtl/knight_move_gen.sv | 148 ++++++++++++++
 tb/tb_knight_move_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/knight_move_gen_if.sv
// Request/result bus between the move-selection logic and knight_move_gen.
// The board bus is shared with the knight-square scanner.
interface knight_move_gen_if;
    logic         start;
    logic [5:0]   square;
    logic [255:0] board;
    logic         busy;
    logic         done;
    logic [63:0]  move_mask;
    logic [63:0]  capture_mask;
    logic [3:0]   move_count;
    logic         bad_origin;

    modport master (
        output start, square, board,
        input  busy, done, move_mask, capture_mask, move_count, bad_origin
    );

    modport slave (
        input  start, square, board,
        output busy, done, move_mask, capture_mask, move_count, bad_origin
    );
endinterface

// File: rtl/knight_move_gen.sv
// Knight move sequencer/collector: walks the eight knight directions through
// the scanner and accumulates legal-target and capture masks plus a count.
module knight_move_gen (
    input  logic             clk,
    input  logic             rst_n,
    knight_move_gen_if.slave mg,
    output logic [5:0]       scan_position,
    output logic [2:0]       scan_direction,
    input  logic [5:0]       scan_nearest_position,
    input  logic [2:0]       scan_nearest_piece
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   step_q;
    logic         mover_q;
    logic         inb_q;
    logic [63:0]  move_mask_q, capture_mask_q;
    logic [3:0]   count_q;
    logic         bad_q;
    logic [5:0]   scan_pos_q;
    logic [2:0]   scan_dir_q;

    logic         accept;
    logic [3:0]   origin_nib;
    logic         origin_empty;
    logic [2:0]   org_file, org_rank;
    logic         inb_d;
    logic [3:0]   result_nib;
    logic         result_enemy;
    logic         result_legal;
    logic         result_capture;

    assign accept       = mg.start && (state_q != SCAN);
    assign origin_nib   = mg.board[{mg.square, 2'b00} +: 4];
    assign origin_empty = (origin_nib[2:0] == 3'b000);

    assign org_file = scan_pos_q[2:0];
    assign org_rank = scan_pos_q[5:3];

    // Result colour comes from the board bus; the type comes from the scanner.
    assign result_nib     = mg.board[{scan_nearest_position, 2'b00} +: 4];
    assign result_enemy   = (result_nib[3] != mover_q);
    assign result_legal   = (scan_nearest_piece == 3'b000) || result_enemy;
    assign result_capture = (scan_nearest_piece != 3'b000) && result_enemy;

    // In-bounds flag for the direction issued this step; the scanner output is stale when off-board.
    always_comb begin
        inb_d = 1'b0;
        case (step_q[2:0])
            3'd0: inb_d = (org_file >= 3'd2) && (org_rank >= 3'd1);
            3'd1: inb_d = (org_file >= 3'd1) && (org_rank >= 3'd2);
            3'd2: inb_d = (org_file <= 3'd6) && (org_rank >= 3'd2);
            3'd3: inb_d = (org_file <= 3'd5) && (org_rank >= 3'd1);
            3'd4: inb_d = (org_file <= 3'd5) && (org_rank <= 3'd6);
            3'd5: inb_d = (org_file <= 3'd6) && (org_rank <= 3'd5);
            3'd6: inb_d = (org_file >= 3'd1) && (org_rank <= 3'd5);
            3'd7: inb_d = (org_file >= 3'd2) && (org_rank <= 3'd6);
            default: inb_d = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: an empty origin skips the sweep entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mg.start) begin
                    state_d = origin_empty ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (step_q == 4'd8) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (mg.start) begin
                    state_d = origin_empty ? DONE : SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: issue direction s while consuming the scanner result for s-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q         <= '0;
            mover_q        <= 1'b0;
            inb_q          <= 1'b0;
            move_mask_q    <= '0;
            capture_mask_q <= '0;
            count_q        <= '0;
            bad_q          <= 1'b0;
            scan_pos_q     <= '0;
            scan_dir_q     <= '0;
        end else if (accept) begin
            step_q         <= '0;
            mover_q        <= origin_nib[3];
            inb_q          <= 1'b0;
            move_mask_q    <= '0;
            capture_mask_q <= '0;
            count_q        <= '0;
            bad_q          <= origin_empty;
            if (!origin_empty) begin
                scan_pos_q <= mg.square;
                scan_dir_q <= '0;
            end
        end else if (state_q == SCAN) begin
            step_q <= step_q + 4'd1;
            inb_q  <= inb_d;
            if (step_q < 4'd7) begin
                scan_dir_q <= step_q[2:0] + 3'd1;
            end
            if ((step_q != 4'd0) && inb_q && result_legal &&
                !move_mask_q[scan_nearest_position]) begin
                move_mask_q[scan_nearest_position] <= 1'b1;
                if (result_capture) begin
                    capture_mask_q[scan_nearest_position] <= 1'b1;
                end
                if (count_q != 4'd8) begin
                    count_q <= count_q + 4'd1;
                end
            end
        end
    end

    assign scan_position   = scan_pos_q;
    assign scan_direction  = scan_dir_q;
    assign mg.busy         = (state_q == SCAN);
    assign mg.done         = (state_q == DONE);
    assign mg.move_mask    = move_mask_q;
    assign mg.capture_mask = capture_mask_q;
    assign mg.move_count   = count_q;
    assign mg.bad_origin   = bad_q;
endmodule

// File: tb/tb_knight_move_gen.sv
// Bench for knight_move_gen: behavioural scanner stand-in plus a reference
// model that enumerates knight jumps with plain file/rank arithmetic.
module tb_knight_move_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] scan_position;
    logic [2:0] scan_direction;
    logic [5:0] scan_nearest_position = '0;
    logic [2:0] scan_nearest_piece = '0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int df [8] = '{-2, -1, 1, 2, 2, 1, -1, -2};
    int dr [8] = '{-1, -2, -2, -1, 1, 2, 2, 1};

    knight_move_gen_if mg();

    knight_move_gen dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mg                    (mg),
        .scan_position         (scan_position),
        .scan_direction        (scan_direction),
        .scan_nearest_position (scan_nearest_position),
        .scan_nearest_piece    (scan_nearest_piece)
    );

    always #5 clk = ~clk;

    // Target square of a knight jump, or -1 when it leaves the board.
    function automatic int target(input int sq, input int d);
        int f, r;
        f = sq % 8 + df[d];
        r = sq / 8 + dr[d];
        if (f < 0 || f > 7 || r < 0 || r > 7) return -1;
        return r * 8 + f;
    endfunction

    // Scanner stand-in: registered result; off-board jumps yield garbage.
    always @(posedge clk) begin
        if (target(int'(scan_position), int'(scan_direction)) >= 0) begin
            scan_nearest_position <= 6'(target(int'(scan_position), int'(scan_direction)));
            scan_nearest_piece    <= mg.board[target(int'(scan_position), int'(scan_direction)) * 4 +: 3];
        end else begin
            scan_nearest_position <= 6'($urandom_range(0, 63));
            scan_nearest_piece    <= 3'($urandom_range(0, 7));
        end
    end

    function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] nib);
        b[sq * 4 +: 4] = nib;
        return b;
    endfunction

    function automatic void ref_scan(input logic [255:0] b, input int sq,
                                     output logic [63:0] mm, output logic [63:0] cm,
                                     output logic [3:0] cnt, output logic bad);
        logic [3:0] onib, tnib;
        int t;
        mm = '0; cm = '0; cnt = '0;
        onib = b[sq * 4 +: 4];
        bad = (onib[2:0] == 3'b000);
        if (bad) return;
        for (int d = 0; d < 8; d++) begin
            t = target(sq, d);
            if (t >= 0) begin
                tnib = b[t * 4 +: 4];
                if (tnib[2:0] == 3'b000) begin
                    mm[t] = 1'b1; cnt = cnt + 4'd1;
                end else if (tnib[3] != onib[3]) begin
                    mm[t] = 1'b1; cm[t] = 1'b1; cnt = cnt + 4'd1;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One scan: start (unless already raised), follow it to done, compare.
    // poke_cyc raises a start mid-scan; chain re-starts at next_sq in the done cycle.
    task automatic run_scan(input string tag, input int sq, input int poke_cyc,
                            input bit chain, input int next_sq, input bit prestarted);
        logic [63:0] emm, ecm;
        logic [3:0]  ecnt;
        logic        ebad;
        int          cyc, done_cyc, busy_cnt;
        bit          dir_ok;
        ref_scan(mg.board, sq, emm, ecm, ecnt, ebad);
        if (!prestarted) begin
            @(negedge clk);
            mg.square = 6'(sq);
            mg.start  = 1'b1;
        end
        @(negedge clk);
        mg.start = 1'b0;
        cyc = 1; done_cyc = 0; busy_cnt = 0; dir_ok = 1'b1;
        while (cyc <= 20) begin
            if (mg.busy) busy_cnt++;
            if (!ebad && cyc <= 8 &&
                (scan_direction !== 3'(cyc - 1) || scan_position !== 6'(sq))) dir_ok = 1'b0;
            if (mg.done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == poke_cyc) begin
                mg.square = 6'd0;
                mg.start  = 1'b1;
            end
            @(negedge clk);
            mg.start = 1'b0;
            cyc++;
        end
        check({tag, "/done_cycle"}, 160'(done_cyc), ebad ? 160'd1 : 160'd10);
        check({tag, "/busy_cycles"}, 160'(busy_cnt), ebad ? 160'd0 : 160'd9);
        check({tag, "/directions"}, 160'(dir_ok), 160'd1);
        check({tag, "/move_mask"}, 160'(mg.move_mask), 160'(emm));
        check({tag, "/capture_mask"}, 160'(mg.capture_mask), 160'(ecm));
        check({tag, "/move_count"}, 160'(mg.move_count), 160'(ecnt));
        check({tag, "/bad_origin"}, 160'(mg.bad_origin), 160'(ebad));
        if (chain) begin
            mg.square = 6'(next_sq);
            mg.start  = 1'b1;
        end else begin
            @(negedge clk);
            check({tag, "/done_pulse"}, 160'(mg.done), 160'd0);
            check({tag, "/hold"}, 160'({mg.move_mask, mg.capture_mask, mg.move_count, mg.bad_origin}),
                  160'({emm, ecm, ecnt, ebad}));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 160'({mg.busy, mg.done, mg.bad_origin, mg.move_count, mg.move_mask,
                         mg.capture_mask, scan_position, scan_direction}), 160'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] b;
        logic [63:0]  k27;
        bit           no_done;
        int           sq;

        rst_n     = 1'b0;
        mg.start  = 1'b0;
        mg.square = '0;
        mg.board  = '0;
        #1;
        check_all_zero("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // White knight alone on 27.
        mg.board = put('0, 27, 4'b0010);
        run_scan("k27_empty", 27, 0, 0, 0, 0);
        k27 = (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17) | (64'd1 << 21) |
              (64'd1 << 33) | (64'd1 << 37) | (64'd1 << 42) | (64'd1 << 44);
        check("k27_plan_mask", 160'(mg.move_mask), 160'(k27));
        check("k27_plan_count", 160'(mg.move_count), 160'd8);

        // Corner: only two targets; garbage from off-board directions must be ignored.
        mg.board = put('0, 0, 4'b0010);
        run_scan("k0_corner", 0, 0, 0, 0, 0);
        check("k0_plan_mask", 160'(mg.move_mask), 160'((64'd1 << 10) | (64'd1 << 17)));

        // Capture at 44, own pawn blocks 10.
        b = put('0, 27, 4'b0010);
        b = put(b, 44, 4'b1001);
        b = put(b, 10, 4'b0001);
        mg.board = b;
        run_scan("k27_mixed", 27, 0, 0, 0, 0);
        check("mixed_plan_capture", 160'(mg.capture_mask), 160'(64'd1 << 44));
        check("mixed_plan_count", 160'(mg.move_count), 160'd7);

        // Empty origin.
        run_scan("bad_origin", 5, 0, 0, 0, 0);

        // Reset in cycle 5 of a scan, then a fresh scan.
        mg.board = put('0, 27, 4'b0010);
        @(negedge clk);
        mg.square = 6'd27;
        mg.start  = 1'b1;
        @(negedge clk);
        mg.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_scan_reset");
        no_done = 1'b1;
        repeat (2) @(negedge clk);
        if (mg.done) no_done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mg.done) no_done = 1'b0;
        end
        check("aborted_no_done", 160'(no_done), 160'd1);
        run_scan("after_reset", 27, 0, 0, 0, 0);

        // Ignored start in cycle 4, accepted start in the done cycle.
        b = put('0, 27, 4'b0010);
        b = put(b, 36, 4'b0010);
        b = put(b, 21, 4'b1011);
        b = put(b, 53, 4'b0100);
        mg.board = b;
        run_scan("pair_first", 27, 4, 1, 36, 0);
        run_scan("pair_second", 36, 0, 0, 0, 1);

        // Random boards and origins.
        for (int i = 0; i < 25; i++) begin
            b = '0;
            for (int s = 0; s < 64; s++) begin
                if ($urandom_range(0, 2) == 0)
                    b = put(b, s, {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))});
            end
            sq = int'($urandom_range(0, 63));
            if ($urandom_range(0, 4) != 0)
                b = put(b, sq, {1'($urandom_range(0, 1)), 3'd2});
            mg.board = b;
            run_scan($sformatf("rnd%0d", i), sq, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
